// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator edge-count measurement stage.
package ro_meas_pkg;

    localparam int DEF_WINDOW_W = 16;
    localparam int DEF_COUNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_HOLD = 2'd3
    } meas_state_e;

    // Saturating increment split into its two outcomes: advance the count, or clip.
    function automatic logic sat_step(input logic rise, input logic at_max);
        return rise & ~at_max;
    endfunction

    function automatic logic sat_clip(input logic rise, input logic at_max);
        return rise & at_max;
    endfunction

endpackage

// File: rtl/ro_edge_counter_edge_detect.sv
// Rising-edge detector on the already-synchronised RO line.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic sig_d_q;

    // Previous-cycle copy of the RO line, updated in every FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d_q;

endmodule

// File: rtl/ro_edge_counter.sv
// Counts RO rising edges over a programmable gate window and hands the result
// to the readout logic through a valid/ready handshake.
module ro_edge_counter
    import ro_meas_pkg::*;
#(
    parameter int WINDOW_W = DEF_WINDOW_W,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_in,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                continuous,
    output logic [COUNT_W-1:0]  count_out,
    output logic                count_valid,
    input  logic                count_ready,
    output logic                overflow,
    output logic                busy
);

    meas_state_e         state_q, state_d;
    logic [COUNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
    logic [WINDOW_W-1:0] win_len_q, win_len_d;
    logic [COUNT_W-1:0]  count_out_q, count_out_d;
    logic                count_valid_q, count_valid_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;

    logic rise_s;
    logic at_max_s;
    logic step_s;
    logic clip_s;

    edge_detect u_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise_s)
    );

    assign at_max_s = &edge_cnt_q;
    assign step_s   = sat_step(rise_s, at_max_s);
    assign clip_s   = sat_clip(rise_s, at_max_s);

    // Next-state and datapath update for the IDLE/ARM/GATE/HOLD sequence.
    always_comb begin
        state_d       = state_q;
        edge_cnt_d    = edge_cnt_q;
        win_cnt_d     = win_cnt_q;
        win_len_d     = win_len_q;
        count_out_d   = count_out_q;
        count_valid_d = count_valid_q;
        overflow_d    = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (window_len != {WINDOW_W{1'b0}})) begin
                    win_len_d = window_len;
                    state_d   = ST_ARM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ARM: begin
                edge_cnt_d = {COUNT_W{1'b0}};
                win_cnt_d  = win_len_q;
                overflow_d = 1'b0;
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                edge_cnt_d = edge_cnt_q + COUNT_W'(step_s);
                overflow_d = overflow_q | clip_s;
                win_cnt_d  = win_cnt_q - WINDOW_W'(1);
                // The final gate cycle's own edge is folded into the published count.
                if (win_cnt_q == WINDOW_W'(1)) begin
                    count_out_d   = edge_cnt_q + COUNT_W'(step_s);
                    count_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    state_d       = ST_GATE;
                end
            end
            ST_HOLD: begin
                if (count_ready) begin
                    count_valid_d = 1'b0;
                    state_d       = continuous ? ST_ARM : ST_IDLE;
                end else begin
                    state_d       = ST_HOLD;
                end
            end
            default: begin
                count_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and result registers; reset discards any measurement in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            edge_cnt_q    <= {COUNT_W{1'b0}};
            win_cnt_q     <= {WINDOW_W{1'b0}};
            win_len_q     <= {WINDOW_W{1'b0}};
            count_out_q   <= {COUNT_W{1'b0}};
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            win_cnt_q     <= win_cnt_d;
            win_len_q     <= win_len_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ro_edge_counter.sv
// Directed bench for ro_edge_counter, built with a 4-bit count to reach saturation.
module tb_ro_edge_counter;

    localparam int WW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          clk_en;
    logic          rst;
    logic          sig_in;
    logic          start;
    logic [WW-1:0] window_len;
    logic          continuous;
    logic [CW-1:0] count_out;
    logic          count_valid;
    logic          count_ready;
    logic          overflow;
    logic          busy;

    int errors;
    int checks;

    ro_edge_counter #(.WINDOW_W(WW), .COUNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .start       (start),
        .window_len  (window_len),
        .continuous  (continuous),
        .count_out   (count_out),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: low, 1: 2-high/2-low with rises at c%4==2, 2: toggle (rises on odd c), 3: single pulse
    function automatic logic pat(input int mode, input int c, input int pulse_c);
        case (mode)
            1:       return ((c % 4) >= 2);
            2:       return ((c % 2) == 1);
            3:       return (c == pulse_c);
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL reset_count_out got=%0d exp=0", count_out); end
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_count_valid got=%b exp=0", count_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        clk_en = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    // One complete single-shot measurement: start at cycle 0, result at len+2, then transfer.
    task automatic measure(input string tag, input int len, input int mode, input int pulse_c,
                           input int extra_start, input logic [CW-1:0] exp_cnt, input logic exp_ovf);
        for (int c = 0; c <= len + 1; c++) begin
            start      = (c == 0) || (c == extra_start);
            window_len = (c == extra_start) ? WW'(2) : WW'(len);
            sig_in     = pat(mode, c, pulse_c);
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_arm got=%b exp=1", tag, busy); end
            end
            if (c == len + 1) begin
                checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_early got=%b exp=0", tag, count_valid); end
            end
            cyc();
        end
        start  = 1'b0;
        sig_in = 1'b0;
        checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", tag, count_valid); end
        checks++; if (count_out !== exp_cnt) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, count_out, exp_cnt); end
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL %s_overflow got=%b exp=%b", tag, overflow, exp_ovf); end
        count_ready = 1'b1;
        cyc();
        count_ready = 1'b0;
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_drop got=%b exp=0", tag, count_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle got=%b exp=0", tag, busy); end
    endtask

    task automatic test_basic();
        measure("basic", 20, 1, 0, -1, 4'd5, 1'b0);
    endtask

    task automatic test_gate_edges();
        measure("rise_in_arm", 3, 3, 1, -1, 4'd0, 1'b0);
        measure("rise_last_gate", 3, 3, 4, -1, 4'd1, 1'b0);
    endtask

    task automatic test_saturation();
        measure("saturate", 40, 2, 0, -1, 4'd15, 1'b1);
        measure("after_sat", 5, 0, 0, -1, 4'd0, 1'b0);
    endtask

    task automatic test_start_during_gate();
        measure("start_in_gate", 6, 1, 0, 4, 4'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c;
        continuous = 1'b1;
        c = 0;
        start = 1'b1; window_len = WW'(8); sig_in = pat(1, c, 0);
        cyc(); c++;
        start = 1'b0;
        while (c < 10) begin
            sig_in = pat(1, c, 0);
            cyc(); c++;
        end
        // Result held under backpressure for 10 cycles while the line keeps toggling.
        while (c < 20) begin
            sig_in = pat(1, c, 0);
            checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, count_valid); end
            checks++; if (count_out !== 4'd2) begin errors++; $display("FAIL bp_count c=%0d got=%0d exp=2", c, count_out); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
            cyc(); c++;
        end
        sig_in = pat(1, c, 0);
        count_ready = 1'b1;
        cyc(); c++;
        count_ready = 1'b0;
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%b exp=0", count_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_rearm_busy got=%b exp=1", busy); end
        continuous = 1'b0;
        window_len = WW'(3);
        // Second window: ARM at 21, GATE 22..29 (length kept at 8), result at 30.
        while (c < 30) begin
            sig_in = pat(1, c, 0);
            if (c == 29) begin
                checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL cont_valid_early got=%b exp=0", count_valid); end
            end
            cyc(); c++;
        end
        sig_in = 1'b0;
        checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL cont_valid got=%b exp=1", count_valid); end
        checks++; if (count_out !== 4'd2) begin errors++; $display("FAIL cont_count got=%0d exp=2", count_out); end
        count_ready = 1'b1;
        cyc();
        count_ready = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got=%b exp=0", busy); end
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL cont_no_result got=%b exp=0", count_valid); end
    endtask

    task automatic test_zero_window();
        start = 1'b1; window_len = WW'(0);
        cyc();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_win_busy got=%b exp=0", busy); end
        cyc();
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_win_busy_later got=%b exp=0", busy); end
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL zero_win_valid got=%b exp=0", count_valid); end
    endtask

    task automatic test_reset_mid_gate();
        // Prior run left count_out at 2; a mid-gate reset must clear it without a clock edge.
        start = 1'b1; window_len = WW'(10); sig_in = 1'b0;
        cyc();
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            sig_in = pat(1, c, 0);
            cyc();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", count_valid); end
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            sig_in = pat(1, c, 0);
            cyc();
            checks++; if ((count_valid !== 1'b0) || (count_out !== 4'd0) || (busy !== 1'b0)) begin
                errors++;
                $display("FAIL midrst_stale c=%0d got valid=%b count=%0d busy=%b exp 0/0/0", c, count_valid, count_out, busy);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        clk_en = 1'b0;
        rst = 1'b0; sig_in = 1'b0; start = 1'b0; window_len = WW'(0);
        continuous = 1'b0; count_ready = 1'b0;
        test_reset();
        test_basic();
        test_gate_edges();
        test_saturation();
        test_start_during_gate();
        test_zero_window();
        test_back_to_back();
        test_reset_mid_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
